// File: rtl/ysyx22041405_fetch_queue.sv
// ysyx22041405_fetch_queue
//
// Instruction-fetch front end. Owns the architectural fetch PC, issues one
// outstanding request at a time to instruction memory, and buffers the
// returned {pc, inst} pairs in a DEPTH-entry FIFO that decode drains through
// a valid/ready handshake. A redirect flushes the FIFO, marks any in-flight
// request as stale, and restarts fetch at redirect_pc.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   imem_req_valid/ready/addr   fetch request channel (addr is the current pc)
//   imem_rsp_valid/data         in-order response, one per accepted request
//   redirect_valid/pc           flush and restart fetch at a new PC
//   out_valid/ready/pc/inst     FIFO head towards decode
//   perf_fetch_cnt              accepted request count
//
// Optional feature: define IFU_PERF_CNT_EN to build the request counter
// behind perf_fetch_cnt; otherwise perf_fetch_cnt is tied to zero.

module ysyx22041405_fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [31:0]      out_inst,
    output logic [31:0]      perf_fetch_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_pc;

    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             req_hs;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   count_after_pop;
    logic [CNT_W:0]   count_after_push_pop;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (count != '0);
    assign out_pc         = pc_mem[rd_ptr];
    assign out_inst       = inst_mem[rd_ptr];

    assign req_hs = imem_req_valid & imem_req_ready;
    assign pop    = out_valid & out_ready;
    // A response only lands in the FIFO when we are waiting for a live request
    // and no redirect is discarding it in the same cycle.
    assign push   = (state == WAIT) & imem_rsp_valid & ~redirect_valid;

    // Occupancy projections used to reserve a FIFO slot before requesting.
    assign count_after_pop      = {1'b0, count} - {{CNT_W{1'b0}}, pop};
    assign count_after_push_pop = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1}
                                - {{CNT_W{1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of its inputs.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!redirect_valid && (count_after_pop < DEPTH_C)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    state_nxt = redirect_valid ? DROP : WAIT;
                end else if (redirect_valid) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = (!redirect_valid && (count_after_push_pop < DEPTH_C))
                              ? REQ : IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                // The stale response retires the outstanding request even if
                // another redirect arrives alongside it; pc already holds the
                // newest target.
                if (imem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (req_hs) begin
                req_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (req_hs) begin
                pc <= pc + WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: the small storage array is reset so out_pc/out_inst read
            // zero out of reset instead of undefined contents.
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= req_pc;
                inst_mem[wr_ptr] <= imem_rsp_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (req_hs) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_cnt;
`else
    assign perf_fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx22041405_fetch_queue.sv
// tb_ysyx22041405_fetch_queue
//
// Drives the fetch queue with a small instruction-memory model and a decode
// sink. A transaction-level reference (architectural pc, outstanding/stale
// flag, queue of expected {pc, inst} pairs) is updated once per clock and
// compared against the DUT every cycle; directed phases add explicit checks
// on ordering, throughput, redirect flushing and pc wrap-around.

module tb_ysyx22041405_fetch_queue;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] perf_fetch_cnt;

    ysyx22041405_fetch_queue #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    int checks   = 0;
    int failures = 0;

    // Reference model
    entry_t      exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_inflight_pc;
    logic        m_outstanding;
    logic        m_stale;
    logic [31:0] exp_perf;

    // Memory model
    logic        mem_pending;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_min;
    int          lat_max;

    // Logs for directed checks
    logic [31:0] hs_log[$];
    logic [31:0] popped_pc[$];
    int          pop_cyc[$];
    int          cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc          = RESET_PC;
        m_inflight_pc = '0;
        m_outstanding = 1'b0;
        m_stale       = 1'b0;
        exp_perf      = '0;
        mem_pending   = 1'b0;
        mem_wait      = 0;
        mem_addr      = '0;
        hs_log.delete();
        popped_pc.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_perf", perf_fetch_cnt, 0);
        model_reset();
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // advance the model by the events that happen at the coming edge.
    task automatic step(input logic rdy, input logic ordy, input logic redir,
                        input logic [31:0] rpc);
        logic   hs;
        logic   pop;
        logic   rsp;
        entry_t e;
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp = 1'b0;
        if (mem_pending) begin
            mem_wait--;
            if (mem_wait <= 0) begin
                rsp         = 1'b1;
                mem_pending = 1'b0;
            end
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? (mem_addr ^ XOR_KEY) : $urandom;

        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_pc", out_pc, exp_q[0].pc);
            check("out_inst", out_inst, exp_q[0].inst);
        end
        check("req_gate", imem_req_valid && (m_outstanding || exp_q.size() >= DEPTH), 0);
        if (imem_req_valid) begin
            check("req_addr", imem_req_addr, m_pc);
        end
        check("perf", perf_fetch_cnt, exp_perf);

        hs  = imem_req_valid & rdy;
        pop = out_valid & ordy;
        if (hs) begin
            hs_log.push_back(imem_req_addr);
            m_inflight_pc = m_pc;
            m_outstanding = 1'b1;
            m_stale       = 1'b0;
            m_pc          = m_pc + 32'd4;
`ifdef IFU_PERF_CNT_EN
            exp_perf      = exp_perf + 32'd1;
`endif
            mem_pending   = 1'b1;
            mem_wait      = $urandom_range(lat_max, lat_min);
            mem_addr      = imem_req_addr;
        end
        if (rsp && m_outstanding) begin
            if (!m_stale) begin
                e.pc   = m_inflight_pc;
                e.inst = m_inflight_pc ^ XOR_KEY;
                exp_q.push_back(e);
            end
            m_outstanding = 1'b0;
        end
        if (pop) begin
            popped_pc.push_back(out_pc);
            pop_cyc.push_back(cyc);
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
        if (redir) begin
            exp_q.delete();
            if (m_outstanding) begin
                m_stale = 1'b1;
            end
            m_pc = rpc;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        cyc     = 0;
        lat_min = 1;
        lat_max = 1;

        // Phase 1: steady streaming, zero-wait memory, decode always ready.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p1_hs_seen", hs_log.size() >= 1, 1);
        if (hs_log.size() >= 1) check("p1_first_addr", hs_log[0], 32'h8000_0000);
        check("p1_npop", popped_pc.size() >= 3, 1);
        if (popped_pc.size() >= 3) begin
            check("p1_pop0", popped_pc[0], 32'h8000_0000);
            check("p1_pop1", popped_pc[1], 32'h8000_0004);
            check("p1_pop2", popped_pc[2], 32'h8000_0008);
            check("p1_gap01", pop_cyc[1] - pop_cyc[0], 2);
            check("p1_gap12", pop_cyc[2] - pop_cyc[1], 2);
        end

        // Phase 2: decode stalls until the FIFO fills, then drains.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("p2_req_idle", imem_req_valid, 0);
        check("p2_out_valid", out_valid, 1);
        hs_log.delete();
        popped_pc.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p2_npop", popped_pc.size() >= 3, 1);
        if (popped_pc.size() >= 3) begin
            check("p2_pop0", popped_pc[0], 32'h8000_0000);
            check("p2_pop1", popped_pc[1], 32'h8000_0004);
            check("p2_pop2", popped_pc[2], 32'h8000_0008);
        end
        check("p2_hs_seen", hs_log.size() >= 1, 1);
        if (hs_log.size() >= 1) check("p2_resume_addr", hs_log[0], 32'h8000_0008);

        // Phase 3: slow memory, redirect while the second fetch is in WAIT.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 40 && hs_log.size() < 2; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p3_reach_wait", hs_log.size() >= 2, 1);
        if (hs_log.size() >= 2) check("p3_second_addr", hs_log[1], 32'h8000_0004);
        step(1'b1, 1'b1, 1'b1, 32'h8000_1000);
        popped_pc.delete();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p3_npop", popped_pc.size() >= 1, 1);
        if (popped_pc.size() >= 1) check("p3_pop0", popped_pc[0], 32'h8000_1000);
        n = 0;
        foreach (popped_pc[k]) if (popped_pc[k] == 32'h8000_0004) n++;
        check("p3_no_stale", n, 0);

        // Phase 4: redirect coincides with a decode handshake, FIFO full.
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("p4_full", out_valid, 1);
        step(1'b1, 1'b1, 1'b1, 32'h8000_2000);
        check("p4_flushed", out_valid, 0);
        popped_pc.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p4_npop", popped_pc.size() >= 1, 1);
        if (popped_pc.size() >= 1) check("p4_pop0", popped_pc[0], 32'h8000_2000);

        // Phase 5: pc wrap-around at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        hs_log.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p5_nhs", hs_log.size() >= 2, 1);
        if (hs_log.size() >= 2) begin
            check("p5_addr0", hs_log[0], 32'hFFFF_FFFC);
            check("p5_addr1", hs_log[1], 32'h0000_0000);
        end

        // Phase 6: five accepted requests, the last one dropped by a redirect.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 60 && hs_log.size() < 5; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("p6_reach5", hs_log.size() >= 5, 1);
        step(1'b0, 1'b1, 1'b1, 32'h8000_3000);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
`ifdef IFU_PERF_CNT_EN
        check("p6_perf", perf_fetch_cnt, 32'd5);
`else
        check("p6_perf", perf_fetch_cnt, 32'd0);
`endif

        // Phase 7: randomized traffic against the reference model.
        do_reset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(3, 0) != 0,
                 $urandom_range(2, 0) != 0,
                 $urandom_range(31, 0) == 0,
                 $urandom_range(7, 0) == 0 ? 32'hFFFF_FFF8 : $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx22041405_fetch_queue.md
Name: ysyx22041405_fetch_queue

Overview:
Instruction-fetch front end that drives the instruction-memory request/response interface. It owns the architectural fetch PC and buffers fetched {pc, inst} pairs in a small FIFO. The decode stage consumes those pairs through a valid/ready interface. A redirect input from the execute/branch logic flushes buffered and in-flight instructions and restarts fetch at a new PC.

Parameters:
WIDTH, 32, data/address width in bits.
RESET_PC, 32'h8000_0000, fetch PC loaded on reset.
DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  WIDTH  fetch address.
imem_rsp_valid  input  1  response valid, in order, one per accepted request.
imem_rsp_data  input  32  fetched instruction word.
redirect_valid  input  1  flush and restart fetch.
redirect_pc  input  WIDTH  new fetch PC.
out_valid  output  1  FIFO head valid to decode.
out_ready  input  1  decode accepts head.
out_pc  output  WIDTH  PC of head instruction.
out_inst  output  32  head instruction.
perf_fetch_cnt  output  32  accepted fetch-request count (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC; state = IDLE; FIFO empty.
  - imem_req_valid = 0, out_valid = 0, imem_req_addr = RESET_PC, out_pc = 0, out_inst = 0, perf_fetch_cnt = 0.
- At most one request outstanding. States: IDLE, REQ, WAIT, DROP.
- IDLE:
  - If FIFO count after this cycle's pop < DEPTH, go to REQ next cycle; otherwise stay in IDLE.
- REQ:
  - imem_req_valid = 1 and imem_req_addr = pc, both held stable until handshake.
  - On handshake (valid & ready): req_pc <= pc; pc <= pc + 4 (modulo 2^WIDTH); go to WAIT.
- WAIT:
  - On imem_rsp_valid, push {req_pc, imem_rsp_data} into the FIFO.
  - Then go to REQ if (count + 1 - pop) < DEPTH, else IDLE.
- DROP:
  - Awaits the stale response. On imem_rsp_valid, discard it (no push) and go to IDLE.
- Peak throughput is one instruction per 2 cycles with a zero-wait memory (REQ→WAIT→REQ).
- imem_rsp_valid in IDLE or REQ is a protocol violation: ignored, nothing pushed.
- FIFO and decode interface:
  - out_valid = FIFO non-empty; out_pc and out_inst reflect the head.
  - A pop happens on out_valid & out_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Space is reserved before REQ, so a push never overflows.
- Redirect (highest priority, takes effect at the clock edge):
  - pc <= redirect_pc; FIFO flushed (count = 0) and any same-cycle push or pop discarded; out_valid = 0 next cycle.
  - State transitions on redirect:
    - IDLE → IDLE.
    - REQ without handshake → request withdrawn, IDLE.
    - REQ with handshake in the same cycle → DROP.
    - WAIT without rsp → DROP.
    - WAIT with rsp in the same cycle → response discarded, IDLE.
    - DROP → stays DROP; pc updated again by the latest redirect.
  - First request at the new PC is issued no earlier than 1 cycle after the redirect.
- No alignment checks; redirect_pc is used as given.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: perf_fetch_cnt increments by 1 on every imem request handshake, including requests later dropped. It wraps at 2^32 and is cleared only by reset.
- Undefined: no counter register is built and perf_fetch_cnt is tied to 0.

Test Plan:
- Release reset, memory always ready, rsp one cycle after accept, rsp_data = address ^ 32'hA5A5_A5A5, out_ready = 1 → first imem_req_addr = 32'h8000_0000; out sequence pc 8000_0000, 8000_0004, 8000_0008 with matching inst; one output every 2 cycles.
- Hold out_ready = 0 → count reaches 2 (DEPTH) and imem_req_valid stays 0. Raise out_ready → both entries drain in order and fetch resumes at 8000_0008.
- Memory rsp delayed 3 cycles; redirect to 8000_1000 while in WAIT → stale response discarded. Next out_pc = 8000_1000; no 8000_0004 entry ever appears.
- Redirect to 8000_2000 in the same cycle as an out handshake with 2 entries buffered → flush wins, out_valid = 0 next cycle, next out_pc = 8000_2000.
- Redirect to FFFF_FFFC, then run two fetches → request addresses FFFF_FFFC, then 0000_0000.
- With IFU_PERF_CNT_EN, 5 accepted requests including 1 dropped → perf_fetch_cnt = 5. Without the macro → perf_fetch_cnt = 0.
